vlc_lamp_decoder: RTL and testbench
===================================

Name: vlc_lamp_decoder

Overview:
- Observer and checker on the far end of the vehicle-lighting-controller lamp interface: it reads the two 3-bit lamp buses, not the driver inputs.
- Recovers the active signalling mode (idle / left turn / right turn / hazard) and flags illegal or stuck lamp sequences.
- Counts completed flash sequences.
- Sits beside the lamp controller on the same clock, as an on-chip self-check and a debug readout.

Parameters:
- IDLE_TIMEOUT, 16: consecutive cycles of all-off lamps before the mode returns to idle.
- STUCK_TIMEOUT, 64: consecutive cycles of an unchanged non-zero pattern before a stuck fault is raised.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- left_lamp  in  3  left lamp bus; bit0 is the innermost lamp
- right_lamp  in  3  right lamp bus; bit0 is the innermost lamp
- mode  out  2  decoded mode: 0 idle, 1 left, 2 right, 3 hazard
- mode_valid  out  1  high while mode is non-idle and tracking a legal sequence
- seq_error  out  1  one-cycle pulse on an illegal pattern transition
- stuck_error  out  1  one-cycle pulse on a stuck-pattern timeout
- seq_count  out  8  completed-sequence counter; wraps 255 -> 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. On reset:
  - all outputs are 0;
  - the lamp sample registers are 000/000;
  - both timers are 0;
  - the state is IDLE.
- Input path: the lamp buses are registered once into cur_l and cur_r. The previous sample is held in prv_l and prv_r. A change event occurs when {cur_l, cur_r} != {prv_l, prv_r}.
- Latency: if an input changes before edge k, cur updates at edge k and all outputs reflect the decision at edge k+1.
- Legal per-side step chain: 000 -> 001 -> 011 -> 111 -> 000.
- States and transitions:
  - IDLE to LEFT: change 000/000 -> 001/000.
  - IDLE to RIGHT: change 000/000 -> 000/001.
  - IDLE to HAZARD: change 000/000 -> 111/111.
  - LEFT: legal changes advance the left bus one step along the chain while the right bus stays at 000. RIGHT mirrors this.
  - HAZARD: legal changes are 111/111 -> 000/000 and 000/000 -> 111/111 only.
  - Mode switch: from a 000/000 pattern, any state may take any IDLE entry transition, with no error. Example: LEFT at 000/000, then 111/111, enters HAZARD.
  - Any other change event pulses seq_error and sets the state to IDLE. The counter and timers are not cleared by this except as stated below. The bad pattern stays in prv. The next legal restart requires a change from 000/000.
- Completed sequence: LEFT or RIGHT taking 111 -> 000, or HAZARD taking 111/111 -> 000/000, increments seq_count by 1 (mod 256).
- Idle timer:
  - counts cycles with cur = 000/000 and no change event;
  - on reaching IDLE_TIMEOUT it sets the state to IDLE, with no error pulse;
  - it is cleared on any change event and on any non-zero pattern.
- Stuck timer:
  - counts cycles with a non-zero pattern and no change event, in any state;
  - on reaching STUCK_TIMEOUT it pulses stuck_error once, sets the state to IDLE, and clears itself;
  - it does not re-pulse until a change event occurs;
  - it is cleared on any change event.
- Outputs:
  - mode_valid = (state != IDLE), registered.
  - mode is 0 whenever mode_valid is 0.
- Simultaneous events:
  - A change event takes priority over both timers in the same cycle.
  - seq_error and stuck_error are never high together.
  - On a completing step, the seq_count increment and the state update happen on the same edge.
- Reset mid-sequence returns every output to its reset value immediately (asynchronous assertion). After release, the first change seen is judged against 000/000.
- Timer width is $clog2(max(IDLE_TIMEOUT, STUCK_TIMEOUT)) + 1. Timers saturate and do not wrap.

Decomposition:
- Shared package vlc_pkg holds:
  - mode enum MODE_IDLE, MODE_LEFT, MODE_RIGHT, MODE_HAZARD (2 bits);
  - lamp step constants LAMP_OFF = 000, LAMP_S1 = 001, LAMP_S2 = 011, LAMP_S3 = 111;
  - a next_step function.
- The lamp controller also uses this package.
- One natural sub-module: vlc_pattern_timer. It holds a parameterised saturating counter with a clear input and a one-shot terminal pulse, instantiated twice (idle and stuck).

Test Plan:
- Left sequence: drive left 000, 001, 011, 111, 000, each held 4 cycles, right at 000 -> mode = 1 and mode_valid = 1 from 2 cycles after 001; seq_count goes 0 -> 1 two cycles after the final 000; no error pulses.
- Hazard with mode switch: after a left sequence ends at 000/000, drive 111/111, then 000/000, twice -> mode = 3 with no seq_error; seq_count increments by 2.
- Illegal step: in RIGHT at 000/011, drive 000/001 -> seq_error high for exactly one cycle, 2 cycles after the change; mode = 0 and mode_valid = 0.
- Stuck fault (STUCK_TIMEOUT = 8): hold 011/000 in LEFT -> single stuck_error pulse when the timer reaches 8; mode = 0; no second pulse while the pattern is held.
- Idle return and wrap:
  - IDLE_TIMEOUT = 4: hold 000/000 after a sequence -> mode_valid falls after 4 quiet cycles.
  - Run 256 left sequences -> seq_count reads 0.
- Reset mid-sequence: assert rst_n = 0 while left = 011 -> all outputs 0 asynchronously; after release, drive 011/000 -> seq_error pulses.

Source files
------------

// File: rtl/vlc_pkg.sv
// Shared definitions for the vehicle-lighting-controller lamp interface.
package vlc_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_e;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_S1  = 3'b001;
    localparam logic [2:0] LAMP_S2  = 3'b011;
    localparam logic [2:0] LAMP_S3  = 3'b111;

    function automatic logic [2:0] next_step(input logic [2:0] s);
        logic [2:0] n;
        n = LAMP_OFF;
        case (s)
            LAMP_OFF: n = LAMP_S1;
            LAMP_S1:  n = LAMP_S2;
            LAMP_S2:  n = LAMP_S3;
            default:  n = LAMP_OFF;
        endcase
        return n;
    endfunction

    // Patterns off the chain never count as a legal predecessor.
    function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
        logic on_chain;
        on_chain = (p == LAMP_OFF) || (p == LAMP_S1) ||
                   (p == LAMP_S2) || (p == LAMP_S3);
        return on_chain && (c == next_step(p));
    endfunction

endpackage

// File: rtl/vlc_pattern_timer.sv
// Saturating quiet-cycle counter with clear and a one-shot terminal pulse.
module vlc_pattern_timer #(
    parameter int LIMIT = 16,
    parameter int W     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic fire
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;
    logic         done;

    assign fire = inc & ~clr & ~done & (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (fire) begin
            cnt  <= '0;
            done <= 1'b1;
        end else if (inc && !done) begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vlc_lamp_decoder.sv
// Lamp-bus observer: recovers signalling mode, flags illegal/stuck sequences.
module vlc_lamp_decoder
    import vlc_pkg::*;
#(
    parameter int IDLE_TIMEOUT  = 16,
    parameter int STUCK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] left_lamp,
    input  logic [2:0] right_lamp,
    output logic [1:0] mode,
    output logic       mode_valid,
    output logic       seq_error,
    output logic       stuck_error,
    output logic [7:0] seq_count
);

    localparam int TMAX = (IDLE_TIMEOUT > STUCK_TIMEOUT) ?
                          IDLE_TIMEOUT : STUCK_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;

    logic [2:0] cur_l, cur_r, prv_l, prv_r;
    mode_e      state_q, state_d;
    logic       change, cz, pz;
    logic       err_d, cnt_inc;
    logic       idle_fire, stuck_fire;

    assign change = {cur_l, cur_r} != {prv_l, prv_r};
    assign cz     = (cur_l == LAMP_OFF) && (cur_r == LAMP_OFF);
    assign pz     = (prv_l == LAMP_OFF) && (prv_r == LAMP_OFF);

    vlc_pattern_timer #(.LIMIT(IDLE_TIMEOUT), .W(TW)) u_idle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (change | ~cz),
        .inc   (cz & ~change),
        .fire  (idle_fire)
    );

    vlc_pattern_timer #(.LIMIT(STUCK_TIMEOUT), .W(TW)) u_stuck (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (change),
        .inc   (~cz & ~change),
        .fire  (stuck_fire)
    );

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        cnt_inc = 1'b0;
        if (change) begin
            // Entries from all-off win in any state, giving free mode switches.
            if (pz && cur_l == LAMP_S1 && cur_r == LAMP_OFF) begin
                state_d = MODE_LEFT;
            end else if (pz && cur_l == LAMP_OFF && cur_r == LAMP_S1) begin
                state_d = MODE_RIGHT;
            end else if (pz && cur_l == LAMP_S3 && cur_r == LAMP_S3) begin
                state_d = MODE_HAZARD;
            end else if (state_q == MODE_LEFT &&
                         prv_r == LAMP_OFF && cur_r == LAMP_OFF &&
                         step_ok(prv_l, cur_l)) begin
                cnt_inc = (prv_l == LAMP_S3);
            end else if (state_q == MODE_RIGHT &&
                         prv_l == LAMP_OFF && cur_l == LAMP_OFF &&
                         step_ok(prv_r, cur_r)) begin
                cnt_inc = (prv_r == LAMP_S3);
            end else if (state_q == MODE_HAZARD && cz &&
                         prv_l == LAMP_S3 && prv_r == LAMP_S3) begin
                cnt_inc = 1'b1;
            end else begin
                err_d   = 1'b1;
                state_d = MODE_IDLE;
            end
        end else if (idle_fire || stuck_fire) begin
            state_d = MODE_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_l       <= LAMP_OFF;
            cur_r       <= LAMP_OFF;
            prv_l       <= LAMP_OFF;
            prv_r       <= LAMP_OFF;
            state_q     <= MODE_IDLE;
            mode_valid  <= 1'b0;
            seq_error   <= 1'b0;
            stuck_error <= 1'b0;
            seq_count   <= 8'd0;
        end else begin
            cur_l       <= left_lamp;
            cur_r       <= right_lamp;
            prv_l       <= cur_l;
            prv_r       <= cur_r;
            state_q     <= state_d;
            mode_valid  <= (state_d != MODE_IDLE);
            seq_error   <= err_d;
            stuck_error <= stuck_fire;
            if (cnt_inc) begin
                seq_count <= seq_count + 8'd1;
            end
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_vlc_lamp_decoder.sv
// Randomised and directed bench for vlc_lamp_decoder against a run-length model.
module tb_vlc_lamp_decoder;

    localparam int IT = 4;
    localparam int ST = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] left_lamp = 3'd0;
    logic [2:0] right_lamp = 3'd0;
    logic [1:0] mode;
    logic       mode_valid, seq_error, stuck_error;
    logic [7:0] seq_count;

    int n_pass = 0;
    int n_total = 0;
    int n_err = 0;
    int n_stk = 0;

    always #5 clk = ~clk;

    vlc_lamp_decoder #(.IDLE_TIMEOUT(IT), .STUCK_TIMEOUT(ST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .left_lamp   (left_lamp),
        .right_lamp  (right_lamp),
        .mode        (mode),
        .mode_valid  (mode_valid),
        .seq_error   (seq_error),
        .stuck_error (stuck_error),
        .seq_count   (seq_count)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int pos(input logic [2:0] v);
        case (v)
            3'b000:  return 0;
            3'b001:  return 1;
            3'b011:  return 2;
            3'b111:  return 3;
            default: return -1;
        endcase
    endfunction

    // Single-side step: from p to the next chain position, other side off.
    function automatic bit side_step(input logic [2:0] p, input logic [2:0] c,
                                     input logic [2:0] po, input logic [2:0] co);
        return pos(p) >= 0 && pos(c) == (pos(p) + 1) % 4 && po == 0 && co == 0;
    endfunction

    // Model: p1 = sample now in cur, p2 = sample in prv; run = quiet cycles.
    logic [5:0] p1 = 6'd0, p2 = 6'd0;
    int         run = 0;
    int         m_mode = 0;
    logic [7:0] m_cnt = 8'd0;

    always begin
        bit e_err, e_stk;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            p1 = 0; p2 = 0; run = 0; m_mode = 0; m_cnt = 0;
            chk("rst_mode", mode, 0);
            chk("rst_valid", mode_valid, 0);
            chk("rst_serr", seq_error, 0);
            chk("rst_stuck", stuck_error, 0);
            chk("rst_count", seq_count, 0);
        end else begin
            e_err = 0;
            e_stk = 0;
            if (p1 != p2) begin
                run = 0;
                if (p2 == 0 && p1 == 6'b001_000) m_mode = 1;
                else if (p2 == 0 && p1 == 6'b000_001) m_mode = 2;
                else if (p2 == 0 && p1 == 6'b111_111) m_mode = 3;
                else if (m_mode == 1 && side_step(p2[5:3], p1[5:3], p2[2:0], p1[2:0])) begin
                    if (p2[5:3] == 3'b111) m_cnt++;
                end else if (m_mode == 2 && side_step(p2[2:0], p1[2:0], p2[5:3], p1[5:3])) begin
                    if (p2[2:0] == 3'b111) m_cnt++;
                end else if (m_mode == 3 && p2 == 6'b111_111 && p1 == 0) begin
                    m_cnt++;
                end else begin
                    e_err = 1;
                    m_mode = 0;
                end
            end else begin
                if (run < 1000) run++;
                if (p1 == 0 && run == IT) m_mode = 0;
                if (p1 != 0 && run == ST) begin
                    e_stk = 1;
                    m_mode = 0;
                end
            end
            chk("mode", mode, m_mode);
            chk("mode_valid", mode_valid, int'(m_mode != 0));
            chk("seq_error", seq_error, int'(e_err));
            chk("stuck_error", stuck_error, int'(e_stk));
            chk("seq_count", seq_count, m_cnt);
            n_err += int'(seq_error);
            n_stk += int'(stuck_error);
            p2 = p1;
            p1 = {left_lamp, right_lamp};
        end
    end

    task automatic hold(input logic [2:0] l, input logic [2:0] r, input int n);
        repeat (n) begin
            @(negedge clk);
            left_lamp = l;
            right_lamp = r;
        end
    endtask

    task automatic left_seq(input int h);
        hold(3'b001, 3'b000, h);
        hold(3'b011, 3'b000, h);
        hold(3'b111, 3'b000, h);
        hold(3'b000, 3'b000, h);
    endtask

    function automatic logic [2:0] nxt(input logic [2:0] v);
        case (v)
            3'b000:  return 3'b001;
            3'b001:  return 3'b011;
            3'b011:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    initial begin
        int e0, s0, c, h;
        logic [2:0] rl, rr;
        repeat (3) @(negedge clk);
        chk("reset_mode", mode, 0);
        chk("reset_valid", mode_valid, 0);
        chk("reset_count", seq_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(0, 0, 4);

        hold(3'b001, 0, 4);
        chk("left_entry_mode", mode, 1);
        chk("left_entry_valid", mode_valid, 1);
        hold(3'b011, 0, 4);
        hold(3'b111, 0, 4);
        hold(0, 0, 4);
        chk("left_done_count", seq_count, 1);
        chk("left_no_err", n_err, 0);
        chk("left_no_stuck", n_stk, 0);

        hold(3'b111, 3'b111, 4);
        chk("hazard_mode", mode, 3);
        hold(0, 0, 4);
        hold(3'b111, 3'b111, 4);
        hold(0, 0, 4);
        chk("hazard_count", seq_count, 3);
        chk("hazard_no_err", n_err, 0);

        e0 = n_err;
        hold(0, 3'b001, 4);
        hold(0, 3'b011, 4);
        chk("right_mode", mode, 2);
        hold(0, 3'b001, 4);
        chk("illegal_pulse_cycles", n_err - e0, 1);
        chk("illegal_mode", mode, 0);
        chk("illegal_valid", mode_valid, 0);
        hold(0, 0, 8);

        s0 = n_stk;
        hold(3'b001, 0, 4);
        hold(3'b011, 0, 12);
        chk("stuck_pulse", n_stk - s0, 1);
        chk("stuck_valid", mode_valid, 0);
        hold(3'b011, 0, 12);
        chk("stuck_no_repeat", n_stk - s0, 1);
        hold(0, 0, 4);

        left_seq(4);
        chk("idle_pre_valid", mode_valid, 1);
        hold(0, 0, 6);
        chk("idle_timeout_valid", mode_valid, 0);

        hold(3'b001, 0, 4);
        hold(3'b011, 0, 2);
        chk("pre_reset_mode", mode, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_mode", mode, 0);
        chk("async_valid", mode_valid, 0);
        chk("async_count", seq_count, 0);
        chk("async_serr", seq_error, 0);
        chk("async_stuck", stuck_error, 0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        left_lamp = 3'b011;
        right_lamp = 0;
        rst_n = 1'b1;
        e0 = n_err;
        hold(3'b011, 0, 4);
        chk("post_reset_err", n_err - e0, 1);
        chk("post_reset_mode", mode, 0);

        @(negedge clk);
        rst_n = 1'b0;
        left_lamp = 0;
        right_lamp = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(0, 0, 2);
        repeat (255) left_seq(2);
        hold(0, 0, 2);
        chk("count_255", seq_count, 255);
        left_seq(2);
        hold(0, 0, 2);
        chk("count_wrap", seq_count, 0);

        rl = 0;
        rr = 0;
        repeat (300) begin
            c = $urandom_range(0, 9);
            if (c < 6) begin
                if (rl == 0 && rr == 0) begin
                    case ($urandom_range(0, 2))
                        0: begin rl = 3'b001; rr = 0; end
                        1: begin rl = 0; rr = 3'b001; end
                        default: begin rl = 3'b111; rr = 3'b111; end
                    endcase
                end else if (rr == 0 && pos(rl) > 0) begin
                    rl = nxt(rl);
                end else if (rl == 0 && pos(rr) > 0) begin
                    rr = nxt(rr);
                end else begin
                    rl = 0;
                    rr = 0;
                end
            end else if (c == 6) begin
                rl = 3'($urandom);
                rr = 3'($urandom);
            end else if (c == 7) begin
                rl = 0;
                rr = 0;
            end
            h = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 14)
                                            : $urandom_range(1, 6);
            hold(rl, rr, h);
        end
        hold(0, 0, 3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
